// File: rtl/alu_pkg.sv
// Shared encodings for the 16-bit ALU and the sequential divider that drives it.
package alu_pkg;

   localparam logic [2:0] ALU_OP_AND = 3'b000;
   localparam logic [2:0] ALU_OP_OR  = 3'b001;
   localparam logic [2:0] ALU_OP_ADD = 3'b010;

   localparam int DIV_ITER = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/alu_seq_divider_if.sv
// Start/done handshake bundle between an issuing stage and the sequential divider.
interface alu_seq_divider_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  ready, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output ready, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/alu16bit.sv
// 16-bit ALU slice: optional operand inversion, carry-in, and AND/OR/ADD select.
module alu16bit
   import alu_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        ainvert,
   input  logic        binvert,
   input  logic        cin,
   input  logic [2:0]  op,
   output logic [15:0] result,
   output logic        cout
);

   logic [15:0] aa;
   logic [15:0] bb;
   logic [15:0] sum;

   assign aa = ainvert ? ~a : a;
   assign bb = binvert ? ~b : b;
   assign {cout, sum} = {1'b0, aa} + {1'b0, bb} + {16'd0, cin};

   always_comb begin
      result = '0;
      case (op)
         ALU_OP_AND: result = aa & bb;
         ALU_OP_OR:  result = aa | bb;
         ALU_OP_ADD: result = sum;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider; one ALU subtract per iteration, cout = no-borrow.
module alu_seq_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_seq_divider_if.slave  bus
);

   if (WIDTH != 16) begin : g_width_check
      $error("alu_seq_divider: WIDTH must be 16 to match alu16bit");
   end

   localparam int CNT_W = $clog2(DIV_ITER);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

   div_state_t       state, state_nxt;
   logic [WIDTH-1:0] d_reg, q_reg, r_reg;
   logic [CNT_W-1:0] cnt;
   logic             dz_reg;

   logic [WIDTH-1:0] s;
   logic             msb, take;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;
   logic             alu_ainvert, alu_binvert, alu_cin;
   logic [2:0]       alu_op;

   assign msb  = r_reg[WIDTH-1];
   assign s    = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
   // A 1 shifted out of R means S >= 2^16 > D, so the wrapped ALU result is the true difference.
   assign take = alu_cout | msb;

   alu16bit u_alu (
      .a       (s),
      .b       (d_reg),
      .ainvert (alu_ainvert),
      .binvert (alu_binvert),
      .cin     (alu_cin),
      .op      (alu_op),
      .result  (alu_result),
      .cout    (alu_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.ready   = 1'b0;
      bus.done    = 1'b0;
      alu_ainvert = 1'b0;
      alu_binvert = 1'b1;
      alu_cin     = 1'b1;
      alu_op      = ALU_OP_ADD;
      case (state)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : CALC;
         end
         CALC: if (cnt == LAST_ITER) state_nxt = DONE;
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_reg  <= '0;
         q_reg  <= '0;
         r_reg  <= '0;
         cnt    <= '0;
         dz_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               d_reg <= bus.divisor;
               cnt   <= '0;
               // Divide-by-zero pre-loads the architectural result and skips iteration.
               if (bus.divisor == '0) begin
                  q_reg  <= '1;
                  r_reg  <= bus.dividend;
                  dz_reg <= 1'b1;
               end else begin
                  q_reg  <= bus.dividend;
                  r_reg  <= '0;
                  dz_reg <= 1'b0;
               end
            end
            CALC: begin
               r_reg <= take ? alu_result : s;
               q_reg <= {q_reg[WIDTH-2:0], take};
               cnt   <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient    = q_reg;
   assign bus.remainder   = r_reg;
   assign bus.div_by_zero = dz_reg;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed-vector and corner-case bench for alu_seq_divider.
module tb_alu_seq_divider;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_seq_divider_if #(.WIDTH(16)) bus ();

   alu_seq_divider #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;
   int k_cyc   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_start", {31'd0, bus.ready}, 32'd1);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      k_cyc     = cyc;
      bus.start = 1'b0;
   endtask

   // Waits for done, records latency and results, then checks pulse width and hold.
   task automatic wait_done(input string tag, output int lat,
                            output logic [15:0] q, output logic [15:0] r, output logic dz);
      int n;
      n = 0; lat = -1; q = '0; r = '0; dz = 1'b0;
      while (n < 40) begin
         @(negedge clk);
         if (bus.done) begin
            lat = cyc - k_cyc;
            q   = bus.quotient;
            r   = bus.remainder;
            dz  = bus.div_by_zero;
            break;
         end
         n++;
      end
      if (lat < 0) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      chk({tag, "_done_width"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_ready_after"}, {31'd0, bus.ready}, 32'd1);
      chk({tag, "_hold"}, {bus.quotient, bus.remainder}, {q, r});
   endtask

   vec_t vecs[11];

   initial begin
      int lat;
      logic [15:0] q, r, a, b;
      logic dz;
      int seen;

      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

      vecs[0]  = '{16'd100,   16'd7,      16'd14,    16'd2,      1'b0, 16};
      vecs[1]  = '{16'hFFFF,  16'h8001,   16'd1,     16'h7FFE,   1'b0, 16};
      vecs[2]  = '{16'h8000,  16'hFFFF,   16'd0,     16'h8000,   1'b0, 16};
      vecs[3]  = '{16'd1234,  16'd0,      16'hFFFF,  16'd1234,   1'b1, 0};
      vecs[4]  = '{16'd40000, 16'd3,      16'd13333, 16'd1,      1'b0, 16};
      vecs[5]  = '{16'hFFFF,  16'd1,      16'hFFFF,  16'd0,      1'b0, 16};
      vecs[6]  = '{16'd0,     16'd5,      16'd0,     16'd0,      1'b0, 16};
      vecs[7]  = '{16'd5,     16'd10,     16'd0,     16'd5,      1'b0, 16};
      vecs[8]  = '{16'd1000,  16'd1000,   16'd1,     16'd0,      1'b0, 16};
      vecs[9]  = '{16'hFFFF,  16'hFFFF,   16'd1,     16'd0,      1'b0, 16};
      vecs[10] = '{16'd0,     16'd0,      16'hFFFF,  16'd0,      1'b1, 0};

      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, bus.ready}, 32'd1);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_results", {bus.quotient, bus.remainder}, 32'd0);
      chk("rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done($sformatf("vec%0d", i), lat, q, r, dz);
         chk($sformatf("vec%0d_q", i), {16'd0, q}, {16'd0, vecs[i].q});
         chk($sformatf("vec%0d_r", i), {16'd0, r}, {16'd0, vecs[i].r});
         chk($sformatf("vec%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      end

      // start while busy is ignored, and later operand changes have no effect
      start_op(16'd500, 16'd9);
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.dividend = 16'd7; bus.divisor = 16'd1;
      chk("busy_ready_low", {31'd0, bus.ready}, 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done("busy", lat, q, r, dz);
      chk("busy_q", {16'd0, q}, 32'd55);
      chk("busy_r", {16'd0, r}, 32'd5);
      chk("busy_lat", lat, 16);

      // start held through DONE: second op accepted on first IDLE edge (18-cycle throughput)
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
      @(posedge clk);
      #1;
      k_cyc = cyc;
      bus.dividend = 16'd50; bus.divisor = 16'd5;
      wait_done("b2b_first", lat, q, r, dz);
      chk("b2b_first_q", {q, r}, {16'd14, 16'd2});
      chk("b2b_first_lat", lat, 16);
      @(posedge clk);
      #1;
      chk("b2b_accept_gap", cyc - k_cyc, 18);
      k_cyc = cyc;
      bus.start = 1'b0;
      wait_done("b2b_second", lat, q, r, dz);
      chk("b2b_second_q", {q, r}, {16'd10, 16'd0});
      chk("b2b_second_lat", lat, 16);

      // asynchronous reset mid-calculation
      start_op(16'd40000, 16'd3);
      repeat (8) @(posedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_results", {bus.quotient, bus.remainder}, 32'd0);
      chk("midrst_dz", {31'd0, bus.div_by_zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("midrst_no_done", seen, 0);
      start_op(16'd40000, 16'd3);
      wait_done("postrst", lat, q, r, dz);
      chk("postrst_qr", {q, r}, {16'd13333, 16'd1});

      // random sweep against the reference model
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
         if (b == 16'd0) b = 16'd1;
         start_op(a, b);
         wait_done($sformatf("rnd%0d", i), lat, q, r, dz);
         chk($sformatf("rnd%0d_%0d_div_%0d", i, a, b), {q, r}, {a / b, a % b});
         chk($sformatf("rnd%0d_lat", i), lat, 16);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
